// File: rtl/timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Define TIMER_MMSS_EN to make digits 1 and 3 mod-6, giving an MM:SS countdown.
package timer_pkg;

  // IDLE: loaded or cleared, waiting | RUNNING: counting ticks | PAUSED: held | DONE: reached zero
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } timer_state_e;

  localparam logic [3:0] BCD_MAX       = 4'd9;
  localparam logic [3:0] MMSS_TENS_MAX = 4'd5;

`ifdef TIMER_MMSS_EN
  localparam bit MMSS_EN = 1'b1;
`else
  localparam bit MMSS_EN = 1'b0;
`endif

  function automatic logic [3:0] digit_max(input int index);
    return (MMSS_EN && (index == 1 || index == 3)) ? MMSS_TENS_MAX : BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD decade of the countdown chain; wraps 0 -> MAX and borrows from the next stage.
module bcd_down_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clock,
  input  logic       clearn,
  input  logic       en,
  input  logic       load,
  input  logic       clear,
  input  logic [3:0] data,
  output logic [3:0] digit,
  output logic       borrow_out
);

  assign borrow_out = en && (digit == 4'd0);

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      digit <= 4'd0;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= data;
    end else if (en) begin
      digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with idle/run/pause/done control and optional auto-reload.
// Digit moduli follow TIMER_MMSS_EN (see timer_pkg).
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic                    clock,
  input  logic                    clearn,
  input  logic                    tick,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic                    loadn,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    cancel,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    zero,
  output logic                    done,
  output logic                    running,
  output logic [1:0]              state
);

  localparam int W = 4 * NUM_DIGITS;

  timer_state_e state_q, next_state;

  logic [W-1:0]        data_clamped;
  logic [W-1:0]        reload_q;
  logic [W-1:0]        load_value;
  logic [NUM_DIGITS:0] en_chain;
  logic                load_en, clear_en, dec_en, reach_zero, reload_wr;
  logic                count_one;
  logic                unused_top_borrow;

  assign zero              = (digits == '0);
  assign count_one         = (digits == W'(1));
  assign running           = (state_q == RUNNING);
  assign state             = state_q;
  assign en_chain[0]       = dec_en;
  assign unused_top_borrow = en_chain[NUM_DIGITS];

  always_comb begin
    logic [3:0] nib;
    data_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib = data[4*i +: 4];
      data_clamped[4*i +: 4] = (nib > digit_max(i)) ? digit_max(i) : nib;
    end
  end

  always_comb begin
    next_state = state_q;
    load_en    = 1'b0;
    clear_en   = 1'b0;
    dec_en     = 1'b0;
    reach_zero = 1'b0;
    reload_wr  = 1'b0;
    load_value = data_clamped;
    if (cancel) begin
      next_state = IDLE;
      clear_en   = 1'b1;
    end else if (!loadn && state_q != RUNNING) begin
      next_state = IDLE;
      load_en    = 1'b1;
      reload_wr  = 1'b1;
    end else if (pause) begin
      if (state_q == RUNNING) next_state = PAUSED;
    end else if (start && state_q != RUNNING) begin
      if (!zero) next_state = RUNNING;
    end else if (tick && state_q == RUNNING && !zero) begin
      if (count_one) begin
        reach_zero = 1'b1;
        // A zero reload value would restart at zero, so it ends the run instead.
        if (AUTO_RELOAD && reload_q != '0) begin
          load_en    = 1'b1;
          load_value = reload_q;
        end else begin
          clear_en   = 1'b1;
          next_state = DONE;
        end
      end else begin
        dec_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q  <= IDLE;
      done     <= 1'b0;
      reload_q <= '0;
    end else begin
      state_q <= next_state;
      done    <= reach_zero;
      if (reload_wr) reload_q <= data_clamped;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_down_digit #(.MAX(digit_max(i))) u_digit (
      .clock      (clock),
      .clearn     (clearn),
      .en         (en_chain[i]),
      .load       (load_en),
      .clear      (clear_en),
      .data       (load_value[4*i +: 4]),
      .digit      (digits[4*i +: 4]),
      .borrow_out (en_chain[i+1])
    );
  end

endmodule
